// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
//   br_type_e   : control-flow class recorded in the BTB and reported by EX
//   CTR_*       : 2-bit PHT counter encodings (strongly/weakly not-taken/taken)
//   ctr_update  : 2-bit saturating counter step
package bp_pkg;

  typedef enum logic [1:0] {
    BR_COND = 2'd0,
    BR_JUMP = 2'd1,
    BR_CALL = 2'd2,
    BR_RET  = 2'd3
  } br_type_e;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  // Counter moves one step towards the resolved direction and sticks at the ends.
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Return-address stack for the fetch-stage predictor.
// Ports:
//   clk, reset        : clock, synchronous active-high reset (clears count/pointer)
//   push, push_addr   : push a return address (a push when full overwrites the oldest)
//   pop               : pop the top entry (ignored when empty)
//   top               : current top-of-stack address (valid when !empty)
//   empty             : no entries held
module bp_ras
  import bp_pkg::*;
#(
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_addr,
  output logic [31:0] top,
  output logic        empty
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(RAS_DEPTH);

  logic [31:0]      stack [RAS_DEPTH];
  // ptr is the next free slot; it wraps freely, so a push into a full stack
  // lands on the oldest entry and the ring keeps the newest RAS_DEPTH returns.
  logic [PTR_W-1:0] ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] top_idx;

  assign top_idx = ptr - PTR_W'(1);
  assign top     = stack[top_idx];
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (count != FULL) count <= count + (PTR_W+1)'(1);
    end else if (pop && !empty) begin
      ptr   <= top_idx;
      count <= count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) stack[ptr] <= push_addr;
  end

endmodule

// File: rtl/gshare_ras_predictor.sv
// Fetch-stage branch predictor: gshare PHT + valid-tagged BTB + return-address stack.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   current_pc, fetch_fire          : fetch PC; fetch_fire commits RAS push/pop for it
//   pred_taken, pred_pc, btb_hit    : combinational prediction from registered state
//   upd_valid, upd_pc, upd_type,
//   upd_taken, upd_target           : resolved control-flow outcome from EX
module gshare_ras_predictor
  import bp_pkg::*;
#(
  parameter int         IDX_BITS  = 5,
  parameter int         HIST_BITS = 5,
  parameter logic [1:0] CTR_INIT  = 2'b11,
  parameter int         RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] current_pc,
  input  logic        fetch_fire,
  output logic        pred_taken,
  output logic [31:0] pred_pc,
  output logic        btb_hit,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [1:0]  upd_type,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  logic                 btb_valid  [ENTRIES];
  logic [TAG_W-1:0]     btb_tag    [ENTRIES];
  logic [31:0]          btb_target [ENTRIES];
  br_type_e             btb_type   [ENTRIES];
  logic [1:0]           pht        [ENTRIES];
  logic [HIST_BITS-1:0] ghr;

  // Fetch-side lookup
  logic [IDX_BITS-1:0] f_idx, f_pht_idx;
  logic [TAG_W-1:0]    f_tag;
  br_type_e            f_type;
  logic [31:0]         pc_plus4;
  logic                ras_push, ras_pop, ras_empty;
  logic [31:0]         ras_top;

  assign f_idx     = current_pc[IDX_BITS+1:2];
  assign f_tag     = current_pc[31:IDX_BITS+2];
  // GHR may be narrower than the index; it is zero-extended before the XOR.
  assign f_pht_idx = f_idx ^ IDX_BITS'(ghr);
  assign f_type    = btb_type[f_idx];
  assign btb_hit   = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
  assign pc_plus4  = current_pc + 32'd4;

  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = pc_plus4;
    if (btb_hit) begin
      unique case (f_type)
        BR_COND: begin
          pred_taken = pht[f_pht_idx][1];
          if (pht[f_pht_idx][1]) pred_pc = btb_target[f_idx];
        end
        BR_JUMP, BR_CALL: begin
          pred_taken = 1'b1;
          pred_pc    = btb_target[f_idx];
        end
        BR_RET: begin
          pred_taken = 1'b1;
          pred_pc    = ras_empty ? btb_target[f_idx] : ras_top;
        end
        default: ;
      endcase
    end
  end

  // The RAS is speculative: it moves with fetch and is never repaired from EX.
  assign ras_push = fetch_fire && btb_hit && (f_type == BR_CALL);
  assign ras_pop  = fetch_fire && btb_hit && (f_type == BR_RET);

  bp_ras #(
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_addr (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  // Update side (resolved outcomes from EX)
  logic [IDX_BITS-1:0] u_idx, u_pht_idx;
  logic [TAG_W-1:0]    u_tag;
  br_type_e            u_type;
  logic                u_cond, btb_write;
  logic [1:0]          unused_upd_pc_lsbs;

  assign unused_upd_pc_lsbs = upd_pc[1:0];
  assign u_idx     = upd_pc[IDX_BITS+1:2];
  assign u_tag     = upd_pc[31:IDX_BITS+2];
  assign u_pht_idx = u_idx ^ IDX_BITS'(ghr);
  assign u_type    = br_type_e'(upd_type);
  assign u_cond    = upd_valid && (u_type == BR_COND);
  // Rewrite the BTB entry only when something about it would change.
  assign btb_write = upd_valid && (!btb_valid[u_idx] ||
                                   (btb_tag[u_idx]    != u_tag) ||
                                   (btb_target[u_idx] != upd_target) ||
                                   (btb_type[u_idx]   != u_type));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        pht[i]       <= CTR_INIT;
      end
      ghr <= '0;
    end else begin
      if (btb_write) btb_valid[u_idx] <= 1'b1;
      if (u_cond) begin
        pht[u_pht_idx] <= ctr_update(pht[u_pht_idx], upd_taken);
        // Shift in the outcome; the cast keeps the low HIST_BITS (works for width 1).
        ghr <= HIST_BITS'({ghr, upd_taken});
      end
    end
  end

  // BTB payload has no reset: valid bits alone decide whether it is used.
  always_ff @(posedge clk) begin
    if (!reset && btb_write) begin
      btb_tag[u_idx]    <= u_tag;
      btb_target[u_idx] <= upd_target;
      btb_type[u_idx]   <= u_type;
    end
  end

endmodule

// File: tb/tb_gshare_ras_predictor.sv
module tb_gshare_ras_predictor;
  import bp_pkg::*;

  localparam int IDX_BITS  = 5;
  localparam int HIST_BITS = 5;
  localparam int RAS_DEPTH = 4;
  localparam int N         = 1 << IDX_BITS;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] current_pc;
  logic        fetch_fire;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        btb_hit;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_type;
  logic        upd_taken;
  logic [31:0] upd_target;

  always #5 clk = ~clk;

  gshare_ras_predictor #(
    .IDX_BITS  (IDX_BITS),
    .HIST_BITS (HIST_BITS),
    .CTR_INIT  (2'b11),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .current_pc (current_pc),
    .fetch_fire (fetch_fire),
    .pred_taken (pred_taken),
    .pred_pc    (pred_pc),
    .btb_hit    (btb_hit),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_type   (upd_type),
    .upd_taken  (upd_taken),
    .upd_target (upd_target)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: tables as plain arrays, RAS as a bounded queue.
  bit          m_valid  [N];
  int unsigned m_tag    [N];
  logic [31:0] m_target [N];
  int          m_type   [N];
  int          m_pht    [N];
  int unsigned m_ghr;
  logic [31:0] m_ras    [$];
  bit          e_hit, e_taken;
  logic [31:0] e_pc;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % N;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * N);
  endfunction

  task automatic model_predict();
    int unsigned i;
    i       = idx_of(current_pc);
    e_hit   = m_valid[i] && (m_tag[i] == tag_of(current_pc));
    e_taken = 1'b0;
    e_pc    = current_pc + 4;
    if (e_hit) begin
      if (m_type[i] == 0) begin
        if (m_pht[i ^ m_ghr] >= 2) begin
          e_taken = 1'b1;
          e_pc    = m_target[i];
        end
      end else if (m_type[i] == 3) begin
        e_taken = 1'b1;
        e_pc    = (m_ras.size() > 0) ? m_ras[$] : m_target[i];
      end else begin
        e_taken = 1'b1;
        e_pc    = m_target[i];
      end
    end
  endtask

  task automatic model_update();
    int unsigned i, p;
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        m_valid[k] = 1'b0;
        m_pht[k]   = 3;
      end
      m_ghr = 0;
      m_ras.delete();
      return;
    end
    if (fetch_fire && e_hit) begin
      i = idx_of(current_pc);
      if (m_type[i] == 2) begin
        m_ras.push_back(current_pc + 4);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end else if (m_type[i] == 3 && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end
    if (upd_valid) begin
      i = idx_of(upd_pc);
      if (upd_type == 2'd0) begin
        p = i ^ m_ghr;
        if (upd_taken) m_pht[p] = (m_pht[p] == 3) ? 3 : m_pht[p] + 1;
        else           m_pht[p] = (m_pht[p] == 0) ? 0 : m_pht[p] - 1;
        m_ghr = ((m_ghr * 2) + (upd_taken ? 1 : 0)) % (1 << HIST_BITS);
      end
      m_valid[i]  = 1'b1;
      m_tag[i]    = tag_of(upd_pc);
      m_target[i] = upd_target;
      m_type[i]   = int'(upd_type);
    end
  endtask

  // Inputs are applied just after posedge; outputs are checked a step later.
  task automatic cycle(input string tag);
    #1;
    model_predict();
    check({tag, "/hit"},   32'(btb_hit),    32'(e_hit));
    check({tag, "/taken"}, 32'(pred_taken), 32'(e_taken));
    check({tag, "/pc"},    pred_pc,         e_pc);
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input string tag, input logic hit, input logic taken, input logic [31:0] pc);
    #1;
    check({tag, "/hit"},   32'(btb_hit),    32'(hit));
    check({tag, "/taken"}, 32'(pred_taken), 32'(taken));
    check({tag, "/pc"},    pred_pc,         pc);
  endtask

  task automatic fetch(input logic [31:0] pc, input logic fire);
    current_pc = pc;
    fetch_fire = fire;
  endtask

  task automatic upd(input logic [31:0] pc, input int t, input logic tk, input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_type   = 2'(t);
    upd_taken  = tk;
    upd_target = tgt;
  endtask

  task automatic noupd();
    upd_valid = 1'b0;
  endtask

  logic [31:0] pool [12];
  logic [31:0] ret_exp [5];

  initial begin
    reset = 1'b1;
    fetch(32'h0, 1'b0);
    upd_valid = 1'b0; upd_pc = '0; upd_type = '0; upd_taken = 1'b0; upd_target = '0;
    model_update();
    @(posedge clk);
    #1;
    cycle("reset");
    reset = 1'b0;

    // Miss after reset, then a taken COND trains the BTB
    fetch(32'h100, 1'b0);
    upd(32'h100, 0, 1'b1, 32'h80);
    peek("rst_miss", 1'b0, 1'b0, 32'h104);
    cycle("train_cond");
    noupd();
    peek("cond_hit", 1'b1, 1'b1, 32'h80);
    cycle("cond_hit");

    // Not-taken training flushes the GHR to zero, then saturates the counter at 0
    repeat (10) begin
      upd(32'h100, 0, 1'b0, 32'h80);
      cycle("nt_train");
    end
    noupd();
    peek("cond_nt", 1'b1, 1'b0, 32'h104);
    cycle("cond_nt");

    // CALL/RET pairing and RET fallback with an empty RAS
    upd(32'h200, 2, 1'b0, 32'h400); cycle("train_call");
    upd(32'h410, 3, 1'b0, 32'h600); cycle("train_ret");
    noupd();
    fetch(32'h200, 1'b1); peek("call", 1'b1, 1'b1, 32'h400);      cycle("call");
    fetch(32'h410, 1'b1); peek("ret_ras", 1'b1, 1'b1, 32'h204);   cycle("ret_ras");
    peek("ret_empty", 1'b1, 1'b1, 32'h600);                       cycle("ret_empty");

    // Overfill the RAS: the oldest return is lost
    for (int k = 1; k <= 5; k++) begin
      upd(32'(k * 16), 2, 1'b0, 32'h1000 + 32'(k));
      cycle("train_calls");
    end
    upd(32'hC8, 3, 1'b0, 32'h700); cycle("train_ret2");
    noupd();
    for (int k = 1; k <= 5; k++) begin
      fetch(32'(k * 16), 1'b1);
      cycle("calls");
    end
    ret_exp[0] = 32'h54; ret_exp[1] = 32'h44; ret_exp[2] = 32'h34;
    ret_exp[3] = 32'h24; ret_exp[4] = 32'h700;
    for (int k = 0; k < 5; k++) begin
      fetch(32'hC8, 1'b1);
      peek($sformatf("ret_full%0d", k), 1'b1, 1'b1, ret_exp[k]);
      cycle("rets");
    end

    // Same-cycle update and fetch to one index
    fetch(32'h10, 1'b0);
    upd(32'h10, 2, 1'b0, 32'h2000);
    peek("same_old", 1'b1, 1'b1, 32'h1001);
    cycle("same_old");
    noupd();
    peek("same_new", 1'b1, 1'b1, 32'h2000);
    cycle("same_new");

    // Reset with a full RAS, with fetch_fire and upd_valid held high
    repeat (5) begin
      fetch(32'h10, 1'b1);
      cycle("refill");
    end
    reset = 1'b1;
    upd(32'h30, 0, 1'b1, 32'h3000);
    cycle("reset_mid");
    reset = 1'b0;
    noupd();
    fetch(32'h10, 1'b0);
    peek("post_rst_miss", 1'b0, 1'b0, 32'h14);
    cycle("post_rst_miss");
    fetch(32'h30, 1'b0);
    peek("post_rst_noupd", 1'b0, 1'b0, 32'h34);
    upd(32'hC8, 3, 1'b0, 32'h700);
    cycle("post_rst_train");
    noupd();
    fetch(32'hC8, 1'b1);
    peek("post_rst_ras_empty", 1'b1, 1'b1, 32'h700);
    cycle("post_rst_ret");

    // Randomized traffic over a small, colliding PC pool
    for (int k = 0; k < 12; k++)
      pool[k] = 32'(($urandom_range(0, 3) << 7) | ($urandom_range(0, 5) << 2));
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      fetch(pool[$urandom_range(0, 11)], 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0)
        upd(pool[$urandom_range(0, 11)], int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
      else
        noupd();
      cycle("rand");
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gshare_ras_predictor.md
# gshare_ras_predictor

Parametrised successor to the fetch-stage branch predictor.
- Combines a gshare pattern history table (PHT) with configurable index and history widths, a valid-tagged branch target buffer (BTB) that records each branch's type, and a return-address stack (RAS) for predicting returns.
- Sits beside the PC register: fetch reads a prediction combinationally every cycle, and EX writes resolved branch outcomes back one update per cycle.

## Interface
Parameters:
- IDX_BITS, 5, BTB/PHT index width; each table has 2^IDX_BITS entries.
- HIST_BITS, 5, global history register (GHR) width; legal range 1..IDX_BITS.
- CTR_INIT, 2'b11, PHT counter value loaded at reset.
- RAS_DEPTH, 4, number of RAS entries; must be a power of two, ≥2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- current_pc  in  32  fetch PC
- fetch_fire  in  1  fetch consumes this cycle's prediction; gates RAS push/pop
- pred_taken  out  1  predicted redirect
- pred_pc  out  32  predicted next PC
- btb_hit  out  1  valid entry with matching tag
- upd_valid  in  1  resolved control-flow instruction present in EX
- upd_pc  in  32  PC of resolved instruction
- upd_type  in  2  br_type_e of resolved instruction
- upd_taken  in  1  actual direction; ignored for non-COND types
- upd_target  in  32  actual target

## Operation
Address fields:
- idx = pc[IDX_BITS+1:2]
- tag = pc[31:IDX_BITS+2]
- pht_idx = idx XOR zero-extended GHR

Prediction (combinational, from pre-edge state):
- Miss: pred_taken=0, pred_pc=current_pc+4.
- Hit, COND: pred_taken=PHT[pht_idx][1]; pred_pc=BTB target if taken, else current_pc+4.
- Hit, JUMP or CALL: pred_taken=1, pred_pc=BTB target.
- Hit, RET, RAS non-empty: pred_taken=1, pred_pc=RAS top.
- Hit, RET, RAS empty: pred_taken=1, pred_pc=BTB target.

RAS (speculative, updated only on fetch_fire && btb_hit):
- CALL: push current_pc+4.
- RET: pop.
- Push when full: circular overwrite of the oldest entry; count stays RAS_DEPTH.
- Pop when empty: no state change.
- No repair after a mispredict.

Update (on upd_valid):
- COND only:
  - Saturating counter at PHT[upd pht_idx], computed with the current GHR: +1 if taken, −1 if not, clamped to 0..3.
  - GHR <= {GHR[HIST_BITS-2:0], upd_taken}; for HIST_BITS=1, GHR <= upd_taken.
- All types: write BTB[upd idx] (tag, target, type, valid=1) when the entry is invalid or its tag, target or type differs.
- A not-taken COND still allocates its entry; the stored target is upd_target.

Reset:
- All BTB valid bits cleared.
- Every PHT counter = CTR_INIT.
- GHR = 0; RAS count and pointer = 0.
- Outputs after reset: btb_hit=0, pred_taken=0, pred_pc=current_pc+4.

## Timing
- Prediction has zero latency and is purely combinational from registered state.
- All state updates land at posedge clk; a prediction made in the same cycle as an update sees pre-update values.
- Update and fetch to the same index in one cycle: fetch sees the old entry; the write lands at the edge.
- RAS push/pop and a BTB write in the same cycle are independent.
- Reset asserted mid-operation: all state is cleared at the next edge, and upd_valid/fetch_fire are ignored in that cycle.
- Counter arithmetic is 2-bit saturating. Index XOR is IDX_BITS wide; the GHR is zero-extended on its upper bits.

## Structure
- Package bp_pkg holds:
  - br_type_e enum: BR_COND=2'd0, BR_JUMP=2'd1, BR_CALL=2'd2, BR_RET=2'd3.
  - Counter constants: CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3.
- Sub-module bp_ras (RAS_DEPTH storage, pointer, saturating count, push/pop/top/empty). The PHT, BTB and GHR stay in the top module.

## Test plan
- Reset, then current_pc=0x100 → btb_hit=0, pred_taken=0, pred_pc=0x104.
- Update COND at 0x100, taken, target 0x80; next cycle current_pc=0x100 → hit; with CTR_INIT=3, pred_taken=1, pred_pc=0x80. The GHR has shifted to 1, so the looked-up pht_idx changes. Check the counter at the old index reads 3.
- Four not-taken updates to the same pht_idx (GHR forced to 0 by a preceding training sequence) → counter reaches 0 and stays 0; a lookup then gives pred_taken=0, pred_pc=pc+4.
- Train CALL at 0x200 (target 0x400) and RET at 0x410; fetch 0x200 with fetch_fire, then 0x410 → pred_pc=0x204. A second RET fetch with the RAS empty → BTB target used.
- RAS_DEPTH=4: five CALL fetches from 0x10, 0x20, 0x30, 0x40, 0x50 → successive RET predictions give 0x54, 0x44, 0x34, 0x24, then fall back to the BTB target.
- Same-cycle update and fetch to one index with a new target → this cycle's pred_pc is the old target; the next cycle's is the new target. Assert reset during the RAS-full case → count=0, btb_hit=0.
